serial_adder_fsm: RTL and testbench
===================================

# serial_adder_fsm

Multi-cycle digit-serial adder built around the full-adder bit cell. It adds two WIDTH-bit operands plus a carry-in, DIGIT bits per clock, and returns a registered WIDTH-bit sum and carry-out. A start/busy/done handshake lets it serve as the low-area add engine for datapaths where a WIDTH-bit ripple adder is too large.

## Interface
Parameters:
- WIDTH, default 8: operand and sum width. Must be ≥ 2 and a multiple of DIGIT.
- DIGIT, default 1: bits processed per cycle. Must be ≥ 1. N = WIDTH/DIGIT is the number of compute cycles.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new add. Sampled only in IDLE or DONE.
- a  input  WIDTH  operand A, unsigned or two's complement. Captured on the accepting edge.
- b  input  WIDTH  operand B. Captured on the accepting edge.
- cin  input  1  carry-in. Captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse marking that sum and cout are valid.
- sum  output  WIDTH  result register.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  two's-complement overflow. Present only with SERIAL_ADDER_FSM_OVF_EN.

## Operation
- Synchronous active-high reset forces:
  - state = IDLE
  - busy = 0, done = 0
  - sum = 0, cout = 0, ovf = 0
  - internal shift registers, carry flop and digit counter = 0
- State machine has three states: IDLE, RUN and DONE.
  - IDLE: start=1 loads a, b and cin into the operand shift registers and carry flop, clears the counter, and moves to RUN. start=0 stays in IDLE.
  - RUN: each edge adds the DIGIT LSBs of both operand registers plus the carry flop through DIGIT chained full-adder cells.
    - The DIGIT result bits shift into the result shift register from the MSB end.
    - The carry flop takes the digit carry-out and the counter increments.
    - On the edge that processes digit N-1, the result shift register and final carry are copied to sum and cout, and the state moves to DONE.
  - DONE: done=1 for exactly this cycle.
    - start=1 here is accepted exactly as from IDLE (back-to-back operation), and the state moves to RUN.
    - start=0 moves to IDLE.
- start is ignored in RUN. It is neither queued nor flagged.
- Operand and cin changes after the accepting edge have no effect.
- sum and cout change only on the edge entering DONE (or on reset). They hold their value through IDLE and the following RUN.
- Arithmetic is modulo 2^WIDTH, and cout is bit WIDTH of a + b + cin. No sign extension is applied.

## Timing
- Edge 0 accepts start. busy=1 for cycles 1..N.
- done=1 and results are valid in cycle N+1, i.e. after the N-th compute edge. Latency from the accepting edge to done is N cycles.
- Throughput is one add per N+1 cycles with start held or re-asserted in DONE.
- rst asserted in any cycle takes effect at that edge and overrides start:
  - an operation in progress is aborted, and done does not pulse for it;
  - outputs return to their reset values.
- With DIGIT = WIDTH (N=1): busy=1 for one cycle, and done follows on the next cycle.

## Configuration
- SERIAL_ADDER_FSM_OVF_EN defined:
  - the ovf port exists;
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1;
  - ovf is registered together with sum/cout and held likewise;
  - ovf resets to 0.
- Not defined: the ovf port and its logic are absent, and all other behaviour is identical.

## Test plan
- WIDTH=8, DIGIT=1: a=0x5A, b=0x3C, cin=0, start pulse -> busy=1 for 8 cycles, then done=1 for one cycle with sum=0x96, cout=0. ovf=1 if enabled (positive+positive gives a negative result).
- WIDTH=8, DIGIT=1: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Next: a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
- WIDTH=8, DIGIT=4: a=0xA5, b=0x5A, cin=1 -> busy=1 for 2 cycles, then sum=0x00, cout=1, ovf=0.
- Back-to-back, WIDTH=8, DIGIT=1: start held high with a=0x01/b=0x02, then a=0x10/b=0x20 presented in the DONE cycle -> done pulses 9 cycles apart with sum=0x03 and then sum=0x30. Operand changes during RUN do not alter either result.
- Reset abort: start with a=0x5A, b=0x3C, then rst=1 in the 3rd RUN cycle -> next cycle busy=0, done=0, sum=0x00, cout=0. No done pulse follows, and a new start afterwards completes normally.
- Exhaustive check, WIDTH=2, DIGIT=1: all 32 combinations of a, b and cin -> {cout,sum} equals a+b+cin each time. start pulses in RUN are ignored.

Source files
------------

// File: rtl/serial_adder_fsm.sv
// Digit-serial adder: DIGIT full-adder cells reused over WIDTH/DIGIT cycles behind a start/busy/done handshake.
// Define SERIAL_ADDER_FSM_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_adder_fsm #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_FSM_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic [DIGIT:0]   w_c;
    logic [DIGIT-1:0] w_s;
    logic [WIDTH-1:0] w_res_next;
    logic             w_last;

    // Carry chain through DIGIT full-adder cells, seeded by the carry flop.
    assign w_c[0] = r_carry;
    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
            assign w_s[gi]   = r_a[gi] ^ r_b[gi] ^ w_c[gi];
            assign w_c[gi+1] = (r_a[gi] & r_b[gi]) | (w_c[gi] & (r_a[gi] ^ r_b[gi]));
        end
        if (DIGIT == WIDTH) begin : g_res_full
            assign w_res_next = w_s;
        end else begin : g_res_shift
            assign w_res_next = {w_s, r_res[WIDTH-1:DIGIT]};
        end
    endgenerate

    assign w_last = (r_cnt == CW'(N - 1));

`ifdef SERIAL_ADDER_FSM_OVF_EN
    logic r_ovf;
    assign ovf = r_ovf;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_FSM_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_res   <= w_res_next;
                    r_carry <= w_c[DIGIT];
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_sum   <= w_res_next;
                        r_cout  <= w_c[DIGIT];
`ifdef SERIAL_ADDER_FSM_OVF_EN
                        // Carry into the sign bit vs. carry out of it.
                        r_ovf   <= w_c[DIGIT-1] ^ w_c[DIGIT];
`endif
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Directed bench for serial_adder_fsm: instances 8/1, 8/4 and 2/1 (WIDTH/DIGIT) share clk and rst.
module tb_serial_adder_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0] t_start = '0;
    logic [2:0] t_cin   = '0;
    logic [7:0] t_a [3];
    logic [7:0] t_b [3];
    logic [1:0] a2, b2;
    assign a2 = t_a[2][1:0];
    assign b2 = t_b[2][1:0];

    logic [2:0] w_busy, w_done, w_cout, w_ovf;
    logic [7:0] w_sum0, w_sum1;
    logic [1:0] w_sum2;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    serial_adder_fsm #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst(rst), .start(t_start[0]), .a(t_a[0]), .b(t_b[0]), .cin(t_cin[0]),
        .busy(w_busy[0]), .done(w_done[0]), .sum(w_sum0), .cout(w_cout[0])
`ifdef SERIAL_ADDER_FSM_OVF_EN
        , .ovf(w_ovf[0])
`endif
    );

    serial_adder_fsm #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .rst(rst), .start(t_start[1]), .a(t_a[1]), .b(t_b[1]), .cin(t_cin[1]),
        .busy(w_busy[1]), .done(w_done[1]), .sum(w_sum1), .cout(w_cout[1])
`ifdef SERIAL_ADDER_FSM_OVF_EN
        , .ovf(w_ovf[1])
`endif
    );

    serial_adder_fsm #(.WIDTH(2), .DIGIT(1)) u_w2d1 (
        .clk(clk), .rst(rst), .start(t_start[2]), .a(a2), .b(b2), .cin(t_cin[2]),
        .busy(w_busy[2]), .done(w_done[2]), .sum(w_sum2), .cout(w_cout[2])
`ifdef SERIAL_ADDER_FSM_OVF_EN
        , .ovf(w_ovf[2])
`endif
    );

`ifndef SERIAL_ADDER_FSM_OVF_EN
    assign w_ovf = '0;
`endif

    function automatic logic [7:0] sum_of(input int u);
        case (u)
            0:       return w_sum0;
            1:       return w_sum1;
            default: return {6'b0, w_sum2};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_done(input int u, input string tag);
        int n = 0;
        while (!w_done[u] && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 32'(w_done[u]), 32'd1);
    endtask

    // Start one add on instance u, scramble inputs after acceptance, then check timing and result.
    task automatic do_add(input int u, input logic [7:0] a, input logic [7:0] b, input logic c,
                          input int n, input logic [7:0] e_sum, input logic e_cout,
                          input logic e_ovf, input bit poke, input string tag);
        int busy_cnt = 0;
        t_a[u] = a; t_b[u] = b; t_cin[u] = c; t_start[u] = 1'b1;
        tick();
        t_start[u] = 1'b0; t_a[u] = ~a; t_b[u] = ~b; t_cin[u] = ~c;
        while (w_busy[u] && busy_cnt < 40) begin
            check({tag, "_nodone_in_run"}, 32'(w_done[u]), 32'd0);
            if (poke && busy_cnt == 0) t_start[u] = 1'b1;
            busy_cnt++;
            tick();
            t_start[u] = 1'b0;
        end
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(n));
        check({tag, "_done"}, 32'(w_done[u]), 32'd1);
        check({tag, "_sum"}, 32'(sum_of(u)), 32'(e_sum));
        check({tag, "_cout"}, 32'(w_cout[u]), 32'(e_cout));
`ifdef SERIAL_ADDER_FSM_OVF_EN
        check({tag, "_ovf"}, 32'(w_ovf[u]), 32'(e_ovf));
`endif
        $display("txn %s: a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d busy=%0d", tag, a, b, c,
                 sum_of(u), w_cout[u], w_ovf[u], busy_cnt);
        tick();
        check({tag, "_done_pulse"}, 32'(w_done[u]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        int pulses;
        logic [2:0] e;
        logic e_ovf;

        for (int u = 0; u < 3; u++) begin
            t_a[u] = '0;
            t_b[u] = '0;
        end
        tick();
        tick();
        for (int u = 0; u < 3; u++) begin
            check($sformatf("rst_busy%0d", u), 32'(w_busy[u]), 32'd0);
            check($sformatf("rst_done%0d", u), 32'(w_done[u]), 32'd0);
            check($sformatf("rst_sum%0d", u), 32'(sum_of(u)), 32'd0);
            check($sformatf("rst_cout%0d", u), 32'(w_cout[u]), 32'd0);
            check($sformatf("rst_ovf%0d", u), 32'(w_ovf[u]), 32'd0);
        end
        rst = 1'b0;
        tick();

        do_add(0, 8'h5A, 8'h3C, 1'b0, 8, 8'h96, 1'b0, 1'b1, 1'b0, "w8d1_5a_3c");
        do_add(0, 8'hFF, 8'h01, 1'b0, 8, 8'h00, 1'b1, 1'b0, 1'b0, "w8d1_ff_01");
        do_add(0, 8'h7F, 8'h01, 1'b0, 8, 8'h80, 1'b0, 1'b1, 1'b0, "w8d1_7f_01");
        do_add(1, 8'hA5, 8'h5A, 1'b1, 2, 8'h00, 1'b1, 1'b0, 1'b0, "w8d4_a5_5a");
        do_add(1, 8'h80, 8'h80, 1'b0, 2, 8'h00, 1'b1, 1'b1, 1'b0, "w8d4_80_80");

        // Back-to-back with start held; operands disturbed mid-run.
        t_a[0] = 8'h01; t_b[0] = 8'h02; t_cin[0] = 1'b0; t_start[0] = 1'b1;
        tick();
        tick(); tick();
        t_a[0] = 8'h77; t_b[0] = 8'h66; t_cin[0] = 1'b1;
        wait_done(0, "b2b_first");
        check("b2b_first_sum", 32'(w_sum0), 32'h03);
        $display("txn b2b_first: sum=%h", w_sum0);
        c0 = cyc;
        t_a[0] = 8'h10; t_b[0] = 8'h20; t_cin[0] = 1'b0;
        tick();
        tick(); tick();
        t_a[0] = 8'hEE; t_b[0] = 8'hDD; t_cin[0] = 1'b1; t_start[0] = 1'b0;
        wait_done(0, "b2b_second");
        check("b2b_spacing", 32'(cyc - c0), 32'd9);
        check("b2b_second_sum", 32'(w_sum0), 32'h30);
        check("b2b_second_cout", 32'(w_cout[0]), 32'd0);
        $display("txn b2b_second: sum=%h spacing=%0d", w_sum0, cyc - c0);
        tick();

        // Reset in the third RUN cycle aborts the add.
        t_a[0] = 8'h5A; t_b[0] = 8'h3C; t_cin[0] = 1'b0; t_start[0] = 1'b1;
        tick();
        t_start[0] = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(w_busy[0]), 32'd0);
        check("abort_done", 32'(w_done[0]), 32'd0);
        check("abort_sum", 32'(w_sum0), 32'd0);
        check("abort_cout", 32'(w_cout[0]), 32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (w_done[0] || w_busy[0]) pulses++;
        end
        check("abort_no_activity", 32'(pulses), 32'd0);
        $display("txn abort: sum=%h cout=%0d", w_sum0, w_cout[0]);
        do_add(0, 8'h5A, 8'h3C, 1'b0, 8, 8'h96, 1'b0, 1'b1, 1'b0, "after_abort");

        // Every WIDTH=2 combination, with a start pulse thrown in during RUN.
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                for (int c = 0; c < 2; c++) begin
                    e = 3'(a) + 3'(b) + 3'(c);
                    e_ovf = (a[1] == b[1]) && (e[1] != a[1]);
                    do_add(2, 8'(a), 8'(b), c[0], 2, {6'b0, e[1:0]}, e[2], e_ovf, 1'b1,
                           $sformatf("w2_%0d_%0d_%0d", a, b, c));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
